lfsr_hist_seq: RTL
==================

Name: lfsr_hist_seq

Overview:
Run controller for the LFSR-to-histogram datapath. It takes a run command (seed, sample count) and sequences the run: clear the histogram bins, load the LFSR seed, pass exactly N generator samples into the histogram, then read back every bin. While reading, it computes the peak bin and exposes run status for the AXI-Lite register file.

Parameters:
DATA_W, 32, width of generator samples and of histogram bin counts
CNT_W, 32, width of the sample counter and of cfg_num_samples
NUM_BINS, 16, number of bins returned by the histogram readout
IDX_W, 4, bin index width; must satisfy 2**IDX_W >= NUM_BINS

Ports:
aclk  in  1  system clock
aresetn  in  1  asynchronous active-low reset
cfg_start  in  1  single-cycle pulse that starts a run
cfg_abort  in  1  single-cycle pulse that aborts a run
cfg_seed  in  DATA_W  LFSR seed, sampled on an accepted start
cfg_num_samples  in  CNT_W  sample count N, sampled on an accepted start
lfsr_seed  out  DATA_W  registered copy of the seed
lfsr_load  out  1  one-cycle seed-load strobe
lfsr_en  out  1  generator step enable
gen_tdata  in  DATA_W  generator sample
gen_tvalid  in  1  generator sample valid
gen_tready  out  1  generator sample ready
m_axis_tdata  out  DATA_W  sample to histogram
m_axis_tvalid  out  1  sample to histogram valid
m_axis_tready  in  1  histogram ready
hist_clear  out  1  one-cycle bin-clear strobe
hist_readout  out  1  bin-dump request; level, held high for the whole readout
s_axis_tdata  in  DATA_W  bin count returned by the histogram
s_axis_tvalid  in  1  bin count valid
s_axis_tready  out  1  bin count ready
sts_busy  out  1  a run is in progress
sts_done  out  1  the last run completed
sts_aborted  out  1  the last run was aborted
sts_samples  out  CNT_W  samples delivered in the current or last run
sts_max_val  out  DATA_W  largest bin count seen
sts_max_idx  out  IDX_W  index of the largest bin

Behaviour:
- Reset: all outputs 0, FSM in IDLE. The async assert takes effect immediately, mid-run included, with no bus handshake completed; deassertion is synchronous to aclk.
- FSM states: IDLE, CLEAR, SEED, RUN, READ, DONE.
- IDLE/DONE + cfg_start: latch cfg_seed into lfsr_seed and cfg_num_samples into an internal N register. Clear sts_samples, sts_max_*, sts_done and sts_aborted. Go to CLEAR.
- cfg_start in CLEAR, SEED, RUN or READ is ignored.
- CLEAR: hist_clear=1 for exactly 1 cycle, then SEED.
- SEED: lfsr_load=1 for exactly 1 cycle. Next state is RUN, or READ if N==0.
- RUN: lfsr_en=1.
  - Combinational pass-through: m_axis_tdata=gen_tdata, m_axis_tvalid=gen_tvalid, gen_tready=m_axis_tready.
  - A beat is counted when gen_tvalid & m_axis_tready; each counted beat does sts_samples+1.
  - On the beat where sts_samples==N-1, go to READ next cycle. Exactly N samples are transferred, never N+1.
- Outside RUN: lfsr_en=0, m_axis_tvalid=0, gen_tready=0.
- READ: hist_readout=1, s_axis_tready=1.
  - Each s_axis beat increments the internal bin index (starts at 0).
  - If s_axis_tdata > sts_max_val (strictly greater), update sts_max_val and sts_max_idx=index. Ties keep the lowest index. If all bins are 0, result is max_val=0, max_idx=0.
  - After the NUM_BINS-th beat: sts_done=1, go to DONE.
- DONE: sts_busy=0; sts_done and the stats hold until the next accepted start.
- sts_busy=1 in CLEAR, SEED, RUN and READ.
- cfg_abort in any non-IDLE/DONE state: next cycle go to IDLE, sts_aborted=1, sts_done=0. All strobes and enables drop. sts_samples holds the partial count.
- cfg_abort in IDLE/DONE has no effect.
- cfg_abort and cfg_start in the same cycle: abort wins, start is dropped.
- Counter width: sts_samples never wraps; N is bounded by CNT_W.
- Latency: start to first hist_clear is 1 cycle; start to RUN is 3 cycles.

Test Plan:
- Reset then start with seed=0xACE1, N=5; histogram always ready; each bin k returns count k -> one clear pulse, one load pulse, lfsr_seed=0xACE1, exactly 5 m_axis beats, sts_max_idx=15, sts_max_val=15, sts_done=1.
- N=4, m_axis_tready toggling 1/0 each cycle and gen_tvalid gaps -> exactly 4 beats, data unchanged, sts_samples=4, no beat counted without a handshake.
- N=0 -> SEED goes straight to READ, zero m_axis beats, 16 bin beats, done.
- Bins all 7 except bin 3=9 and bin 9=9 -> max_val=9, max_idx=3.
- cfg_abort during RUN after 2 of 10 samples -> IDLE next cycle, sts_aborted=1, sts_samples=2, lfsr_en=0. Same-cycle start+abort in RUN -> abort only.
- cfg_start during READ ignored. aresetn pulled low mid-READ -> all outputs 0 immediately, restart runs cleanly.

Source files
------------

// File: rtl/lfsr_hist_seq.sv
// Run controller for the LFSR-to-histogram datapath: clears bins, seeds the LFSR,
// forwards exactly N samples, then reads every bin back while tracking the peak.
module lfsr_hist_seq #(
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 32,
    parameter int NUM_BINS = 16,
    parameter int IDX_W    = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [DATA_W-1:0] cfg_seed,
    input  logic [CNT_W-1:0]  cfg_num_samples,
    output logic [DATA_W-1:0] lfsr_seed,
    output logic              lfsr_load,
    output logic              lfsr_en,
    input  logic [DATA_W-1:0] gen_tdata,
    input  logic              gen_tvalid,
    output logic              gen_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              hist_clear,
    output logic              hist_readout,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic              sts_busy,
    output logic              sts_done,
    output logic              sts_aborted,
    output logic [CNT_W-1:0]  sts_samples,
    output logic [DATA_W-1:0] sts_max_val,
    output logic [IDX_W-1:0]  sts_max_idx
);

    typedef enum logic [2:0] {IDLE, CLEAR, SEED, RUN, READ, DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  num_samples;
    logic [IDX_W-1:0]  bin_idx;
    logic              start_ok, abort_ok, gen_beat, bin_beat, last_bin;

    // Abort outranks start, and only a quiescent controller accepts a new run.
    assign start_ok = cfg_start && !cfg_abort && (state == IDLE || state == DONE);
    assign abort_ok = cfg_abort && !(state == IDLE || state == DONE);
    assign last_bin = (bin_idx == IDX_W'(NUM_BINS - 1));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        lfsr_load     = 1'b0;
        lfsr_en       = 1'b0;
        gen_tready    = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        hist_clear    = 1'b0;
        hist_readout  = 1'b0;
        s_axis_tready = 1'b0;
        sts_busy      = 1'b0;
        gen_beat      = 1'b0;
        bin_beat      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start_ok) state_nxt = CLEAR;
            end
            CLEAR: begin
                hist_clear = 1'b1;
                sts_busy   = 1'b1;
                state_nxt  = SEED;
            end
            SEED: begin
                lfsr_load = 1'b1;
                sts_busy  = 1'b1;
                state_nxt = (num_samples == '0) ? READ : RUN;
            end
            RUN: begin
                lfsr_en       = 1'b1;
                sts_busy      = 1'b1;
                m_axis_tdata  = gen_tdata;
                m_axis_tvalid = gen_tvalid;
                gen_tready    = m_axis_tready;
                gen_beat      = gen_tvalid && m_axis_tready;
                if (gen_beat && sts_samples == num_samples - CNT_W'(1)) state_nxt = READ;
            end
            READ: begin
                hist_readout  = 1'b1;
                s_axis_tready = 1'b1;
                sts_busy      = 1'b1;
                bin_beat      = s_axis_tvalid;
                if (bin_beat && last_bin) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort_ok) state_nxt = IDLE;
    end

    // Run statistics; the peak uses a strict compare so ties keep the lowest bin.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lfsr_seed   <= '0;
            num_samples <= '0;
            sts_samples <= '0;
            sts_max_val <= '0;
            sts_max_idx <= '0;
            bin_idx     <= '0;
            sts_done    <= 1'b0;
            sts_aborted <= 1'b0;
        end else if (start_ok) begin
            lfsr_seed   <= cfg_seed;
            num_samples <= cfg_num_samples;
            sts_samples <= '0;
            sts_max_val <= '0;
            sts_max_idx <= '0;
            bin_idx     <= '0;
            sts_done    <= 1'b0;
            sts_aborted <= 1'b0;
        end else begin
            if (gen_beat) sts_samples <= sts_samples + CNT_W'(1);
            if (bin_beat) begin
                bin_idx <= bin_idx + IDX_W'(1);
                if (s_axis_tdata > sts_max_val) begin
                    sts_max_val <= s_axis_tdata;
                    sts_max_idx <= bin_idx;
                end
                if (last_bin) sts_done <= 1'b1;
            end
            if (abort_ok) begin
                sts_aborted <= 1'b1;
                sts_done    <= 1'b0;
            end
        end
    end

endmodule
